// File: rtl/hog_feature_stream.sv
// HOG feature output stage: buffers normalised blocks and serialises
// them into LANES-cell beats on a valid/ready stream with frame markers.
module hog_feature_stream #(
    parameter int FEA_W  = 32,
    parameter int BIN_N  = 9,
    parameter int CELL_N = 4,
    parameter int LANES  = 1,
    parameter int BID_W  = 13,
    parameter int BLK_N  = 1200,
    parameter int DEPTH  = 8,
    parameter int SLACK  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [BID_W-1:0]              i_bid,
    input  logic [CELL_N*BIN_N*FEA_W-1:0] i_fea,
    output logic                          hold,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [LANES*BIN_N*FEA_W-1:0]  o_data,
    output logic [BID_W-1:0]              o_bid,
    output logic                          o_last,
    output logic                          o_sof,
    output logic                          o_eof,
    output logic                          overflow,
    output logic                          seq_err
);

    localparam int BEATS  = CELL_N / LANES;
    localparam int CELL_W = BIN_N * FEA_W;
    localparam int BEAT_W = LANES * CELL_W;
    localparam int BLK_W  = CELL_N * CELL_W;
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;

    logic [BID_W-1:0] bid_mem [DEPTH];
    logic [BLK_W-1:0] fea_mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [BC_W-1:0]  beat;
    logic [BID_W-1:0] exp_bid;
    logic             hold_q;
    logic             ovf_q;
    logic             seq_q;

    logic [BEATS-1:0][BEAT_W-1:0] head_beats;
    logic [BID_W-1:0]             head_bid;
    logic                         valid;
    logic                         last_beat;
    logic                         fire;
    logic                         pop;
    logic                         push;

    assign valid     = (count != '0);
    assign last_beat = (beat == BC_W'(BEATS - 1));
    assign fire      = valid && o_ready;
    assign pop       = fire && last_beat;
    // A full FIFO still takes a block when the head leaves this cycle.
    assign push      = i_valid && ((count != CW'(DEPTH)) || pop);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers, beat counter, throttle and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            beat    <= '0;
            exp_bid <= '0;
            hold_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            count  <= count_nxt;
            hold_q <= (CW'(DEPTH) - count_nxt) <= CW'(SLACK);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fire) begin
                beat <= last_beat ? '0 : beat + 1'b1;
            end
            if (i_valid && !push) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                if (i_bid != exp_bid) begin
                    seq_q <= 1'b1;
                end
                exp_bid <= (i_bid == BID_W'(BLK_N - 1)) ? '0 : i_bid + 1'b1;
            end
        end
    end

    // Block storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            bid_mem[wr_ptr] <= i_bid;
            fea_mem[wr_ptr] <= i_fea;
        end
    end

    assign head_beats = fea_mem[rd_ptr];
    assign head_bid   = bid_mem[rd_ptr];

    assign hold     = hold_q;
    assign overflow = ovf_q;
    assign seq_err  = seq_q;
    assign o_valid  = valid;
    assign o_data   = valid ? head_beats[beat] : '0;
    assign o_bid    = valid ? head_bid : '0;
    assign o_last   = valid && last_beat;
    assign o_sof    = valid && (beat == '0) && (head_bid == '0);
    assign o_eof    = o_last && (head_bid == BID_W'(BLK_N - 1));

endmodule
